// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and default geometry for the sprite sequencer
package sprite_pkg;

    localparam int DEF_CORDW       = 10;
    localparam int DEF_MAX_SPRITES = 8;
    localparam int DEF_SPR_IDW     = 4;
    localparam int ENTRYW          = 4 + DEF_SPR_IDW + 2 * DEF_CORDW;

    typedef struct packed {
        logic                   valid;
        logic [2:0]             scale;
        logic [DEF_SPR_IDW-1:0] id;
        logic [DEF_CORDW-1:0]   y;
        logic [DEF_CORDW-1:0]   x;
    } sprite_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LOAD,
        S_RUN,
        S_NEXT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/sprite_sequencer.sv
// rtl/sprite_sequencer.sv - per-frame walk of a double-buffered sprite table driving one renderer
module sprite_sequencer
    import sprite_pkg::*;
#(
    parameter int CORDW       = DEF_CORDW,
    parameter int MAX_SPRITES = DEF_MAX_SPRITES,
    parameter int SPR_IDW     = DEF_SPR_IDW,
    localparam int AW = $clog2(MAX_SPRITES),
    localparam int EW = 4 + SPR_IDW + 2 * CORDW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               tbl_we,
    input  logic [AW-1:0]      tbl_waddr,
    input  logic [EW-1:0]      tbl_wdata,
    output logic               r_rst,
    output logic               r_enable,
    output logic [CORDW-1:0]   r_sx,
    output logic [CORDW-1:0]   r_sy,
    output logic [2:0]         r_scale,
    output logic [SPR_IDW-1:0] r_sprite_id,
    input  logic               r_finished,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    logic [1:0] rst_sync;
    logic       rst_int_n;

    // Reset asserts immediately, releases two edges later in this clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [EW-1:0] shadow [MAX_SPRITES];
    logic [EW-1:0] active [MAX_SPRITES];

    seq_state_t    state, state_d;
    logic [AW-1:0] idx, idx_d;
    logic          first_run;
    logic          last;

    logic [EW-1:0]      cur;
    logic               cur_valid;
    logic [2:0]         cur_scale;
    logic [SPR_IDW-1:0] cur_id;
    logic [CORDW-1:0]   cur_y;
    logic [CORDW-1:0]   cur_x;

    assign cur       = active[idx];
    assign cur_valid = cur[EW-1];
    assign cur_scale = cur[EW-2 -: 3];
    assign cur_id    = cur[2*CORDW +: SPR_IDW];
    assign cur_y     = cur[CORDW +: CORDW];
    assign cur_x     = cur[0 +: CORDW];
    assign last      = (idx == AW'(MAX_SPRITES - 1));

    // Snapshot reads the shadow before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (tbl_we) shadow[tbl_waddr] <= tbl_wdata;
            if (state == S_IDLE && frame_start) begin
                for (int i = 0; i < MAX_SPRITES; i++) active[i] <= shadow[i];
            end
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (cur_valid)  state_d = S_LOAD;
                else if (last)  state_d = S_DONE;
                else            idx_d   = idx + AW'(1);
            end
            S_LOAD: state_d = S_RUN;
            // The renderer's flag from the previous sprite may still be visible on the first cycle.
            S_RUN: begin
                if (!first_run && r_finished) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SCAN;
                    idx_d   = idx + AW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            first_run   <= 1'b0;
            r_rst       <= 1'b0;
            r_enable    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_scale     <= '0;
            r_sprite_id <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            first_run <= (state == S_LOAD);
            r_rst     <= (state_d == S_LOAD);
            r_enable  <= (state_d == S_RUN);
            busy      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done      <= (state_d == S_DONE);
            overrun   <= frame_start && (state != S_IDLE);
            if (state == S_SCAN && cur_valid) begin
                r_sx        <= cur_x;
                r_sy        <= cur_y;
                r_scale     <= cur_scale;
                r_sprite_id <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_sprite_sequencer.sv
// tb/tb_sprite_sequencer.sv - self-checking bench for sprite_sequencer
module tb_sprite_sequencer;
    import sprite_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              tbl_we = 1'b0;
    logic [2:0]        tbl_waddr = '0;
    logic [ENTRYW-1:0] tbl_wdata = '0;
    logic              r_rst, r_enable, busy, done, overrun;
    logic [9:0]        r_sx, r_sy;
    logic [2:0]        r_scale;
    logic [3:0]        r_sprite_id;
    logic              r_finished = 1'b0;

    int total = 0;
    int bad   = 0;

    sprite_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
        .r_rst(r_rst), .r_enable(r_enable), .r_sx(r_sx), .r_sy(r_sy),
        .r_scale(r_scale), .r_sprite_id(r_sprite_id), .r_finished(r_finished),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Renderer: finishes after ren_len enabled cycles, flag held until its next reset.
    int   ren_len = 1;
    int   ren_cnt = 0;
    logic ren_rs, ren_en;
    always @(posedge clk) begin
        ren_rs = r_rst;
        ren_en = r_enable;
        #2;
        if (ren_rs) begin
            ren_cnt    = 0;
            r_finished = 1'b0;
        end else if (ren_en) begin
            ren_cnt = ren_cnt + 1;
            if (ren_cnt >= ren_len) r_finished = 1'b1;
        end
    end

    sprite_entry_t shadow_m [8];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic sprite_entry_t mk(input int i, input logic v);
        sprite_entry_t e;
        e.valid = v;
        e.scale = 3'((2 + i) % 8);
        e.id    = 4'((3 + i) % 16);
        e.y     = 10'(100 + 7 * i);
        e.x     = 10'(50 + 30 * i);
        return e;
    endfunction

    task automatic write_entry(input int a, input sprite_entry_t e);
        tbl_we    = 1'b1;
        tbl_waddr = 3'(a);
        tbl_wdata = e;
        step();
        tbl_we = 1'b0;
        shadow_m[a] = e;
    endtask

    task automatic load_mask(input logic [7:0] m);
        for (int i = 0; i < 8; i++) write_entry(i, mk(i, m[i]));
    endtask

    // Runs one frame; wr_at = 0 writes alongside frame_start, -1 means no write; fs_again_at = 0 means none.
    task automatic run_frame(input int len, input int fs_again_at, input int wr_at,
                             input int wr_addr, input sprite_entry_t wr_data,
                             output int done_cyc, output int first_rst);
        sprite_entry_t snap [8];
        logic [26:0]   exp_q [$];
        logic [26:0]   obs_q [$];
        logic [26:0]   cur;
        int            exp_done, cyc, ov_cnt, seq_bad, stab_bad;
        logic          prev_rst, prev_en;

        ren_len = len;
        for (int i = 0; i < 8; i++) snap[i] = shadow_m[i];
        exp_done = 1;
        for (int i = 0; i < 8; i++) begin
            if (snap[i].valid) begin
                exp_q.push_back({snap[i].scale, snap[i].id, snap[i].y, snap[i].x});
                exp_done += len + 4;
            end else begin
                exp_done += 1;
            end
        end

        frame_start = 1'b1;
        if (wr_at == 0) begin
            tbl_we    = 1'b1;
            tbl_waddr = 3'(wr_addr);
            tbl_wdata = wr_data;
            shadow_m[wr_addr] = wr_data;
        end
        step();
        frame_start = 1'b0;
        tbl_we      = 1'b0;
        chk("busy_rise", longint'(busy), 1);

        cyc = 1; done_cyc = -1; first_rst = -1;
        ov_cnt = 0; seq_bad = 0; stab_bad = 0; prev_rst = 1'b0; prev_en = 1'b0;
        while (cyc < 1500) begin
            cur = {r_scale, r_sprite_id, r_sy, r_sx};
            if (r_rst) begin
                obs_q.push_back(cur);
                if (first_rst < 0) first_rst = cyc;
                if (r_enable) seq_bad++;
            end
            if (r_enable && !(prev_rst || prev_en)) seq_bad++;
            if (r_enable && obs_q.size() > 0 && cur != obs_q[obs_q.size()-1]) stab_bad++;
            if (overrun) ov_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            prev_rst    = r_rst;
            prev_en     = r_enable;
            frame_start = (cyc == fs_again_at);
            if (cyc == wr_at) begin
                tbl_we    = 1'b1;
                tbl_waddr = 3'(wr_addr);
                tbl_wdata = wr_data;
                shadow_m[wr_addr] = wr_data;
            end else begin
                tbl_we = 1'b0;
            end
            step();
            cyc++;
        end
        frame_start = 1'b0;
        tbl_we      = 1'b0;

        chk("done_cycle", done_cyc, exp_done);
        chk("draw_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("draw_attr", longint'(obs_q[i]), longint'(exp_q[i]));
        chk("enable_order", seq_bad, 0);
        chk("attr_stable", stab_bad, 0);
        chk("overrun_count", ov_cnt, (fs_again_at > 0) ? 1 : 0);
        step();
        chk("done_once", longint'(done), 0);
        chk("busy_after", longint'(busy), 0);
    endtask

    typedef struct {
        logic [7:0] mask;
        int         len;
        int         exp_done;
        int         exp_first;
        int         exp_draws;
    } vec_t;

    initial begin
        vec_t          vecs [5];
        sprite_entry_t e;
        int            dc, fr, flag, wa, fa;

        vecs[0] = '{8'h01, 10, 22,  2, 1};
        vecs[1] = '{8'h92,  3, 27,  3, 3};
        vecs[2] = '{8'h00,  5,  9, -1, 0};
        vecs[3] = '{8'hFF,  1, 41,  2, 8};
        vecs[4] = '{8'h80,  2, 14,  9, 1};
        for (int i = 0; i < 8; i++) shadow_m[i] = '0;

        // Reset with table writes in flight.
        for (int i = 0; i < 4; i++) begin
            tbl_we    = 1'b1;
            tbl_waddr = 3'(i);
            tbl_wdata = mk(i, 1'b1);
            step();
            chk("reset_outputs", longint'({r_rst, r_enable, busy, done, overrun,
                                           r_sx, r_sy, r_scale, r_sprite_id}), 0);
        end
        tbl_we = 1'b0;
        rst_n  = 1'b1;
        flag = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (r_enable || busy || r_rst) flag++;
        end
        chk("idle_after_reset", flag, 0);

        for (int v = 0; v < 5; v++) begin
            load_mask(vecs[v].mask);
            run_frame(vecs[v].len, 0, -1, 0, '0, dc, fr);
            chk("vec_done_cycle", dc, vecs[v].exp_done);
            chk("vec_first_rst", fr, vecs[v].exp_first);
        end

        // Shadow rewrite and second frame_start during the walk.
        load_mask(8'h01);
        e = mk(0, 1'b1);
        e.x = 10'd200;
        run_frame(10, 8, 5, 0, e, dc, fr);
        chk("first_rst_cycle", fr, 2);
        chk("sx_frame1", longint'(r_sx), 50);
        chk("sy_frame1", longint'(r_sy), 100);
        chk("scale_frame1", longint'(r_scale), 2);
        chk("id_frame1", longint'(r_sprite_id), 3);
        run_frame(4, 0, -1, 0, '0, dc, fr);
        chk("sx_frame2", longint'(r_sx), 200);

        // Reset while the renderer is running.
        ren_len     = 50;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 20 && !r_enable; i++) step();
        step();
        step();
        chk("enable_before_rst", longint'(r_enable), 1);
        rst_n = 1'b0;
        #1;
        chk("enable_async_drop", longint'(r_enable), 0);
        chk("busy_async_drop", longint'(busy), 0);
        for (int i = 0; i < 8; i++) shadow_m[i] = '0;
        step();
        step();
        rst_n = 1'b1;
        flag = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (r_enable || busy || r_rst) flag++;
        end
        chk("idle_after_midrun_reset", flag, 0);
        run_frame(3, 0, -1, 0, '0, dc, fr);
        chk("tables_cleared", fr, -1);

        // Randomized frames against the reference model.
        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < 8; i++) begin
                e.valid = 1'($urandom_range(1));
                e.scale = 3'($urandom_range(7));
                e.id    = 4'($urandom_range(15));
                e.y     = 10'($urandom_range(1023));
                e.x     = 10'($urandom_range(1023));
                write_entry(i, e);
            end
            e.valid = 1'($urandom_range(1));
            e.x     = 10'($urandom_range(1023));
            wa = ($urandom_range(1) == 1) ? 0 : -1;
            fa = ($urandom_range(2) == 0) ? 2 : 0;
            run_frame(int'($urandom_range(6, 1)), fa, wa, int'($urandom_range(7)), e, dc, fr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
